// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: ROM address/data, pipeline control, and IF/ID outputs.
// master = the fetch stage, slave = ROM/decode/hazard environment.
interface instr_fetch_if #(
  parameter int unsigned PC_WIDTH = 16
);
  logic                stall;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [PC_WIDTH-1:0] pc;
  logic [31:0]         instr_in;
  logic                if_valid;
  logic [31:0]         if_instr;
  logic [PC_WIDTH-1:0] if_pc;
  logic [PC_WIDTH-1:0] if_pc4;
  logic                halted;
  logic [PC_WIDTH-1:0] fault_pc;
  logic [31:0]         fetch_count;

  modport master (
    input  stall, redirect, redirect_pc, instr_in,
    output pc, if_valid, if_instr, if_pc, if_pc4, halted, fault_pc, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_pc, instr_in,
    input  pc, if_valid, if_instr, if_pc, if_pc4, halted, fault_pc, fetch_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, latches ROM data into IF/ID, and
// handles stall, redirect flush and misaligned-target halt.
//   state | meaning
//   BOOT  | one settle cycle after reset, nothing latched
//   RUN   | fetching; redirect > stall > advance
//   HALT  | misaligned redirect seen, frozen until reset
module instr_fetch #(
  parameter int unsigned         PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0]         NOP      = 32'h00000013
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                if_valid_q, if_valid_d;
  logic [31:0]         if_instr_q, if_instr_d;
  logic [PC_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [PC_WIDTH-1:0] if_pc4_q, if_pc4_d;
  logic                halted_q, halted_d;
  logic [PC_WIDTH-1:0] fault_pc_q, fault_pc_d;
  logic [31:0]         fetch_count_q, fetch_count_d;
  logic [PC_WIDTH-1:0] pc_plus4;

  assign pc_plus4 = pc_q + PC_STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= NOP;
      if_pc_q       <= '0;
      if_pc4_q      <= '0;
      halted_q      <= 1'b0;
      fault_pc_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc4_q      <= if_pc4_d;
      halted_q      <= halted_d;
      fault_pc_q    <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc4_d      = if_pc4_q;
    halted_d      = halted_q;
    fault_pc_d    = fault_pc_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.redirect) begin
          // Both redirect flavours flush IF/ID; only an aligned target moves the PC.
          if_valid_d = 1'b0;
          if_instr_d = NOP;
          if (bus.redirect_pc[1:0] != 2'b00) begin
            state_d    = HALT;
            halted_d   = 1'b1;
            fault_pc_d = bus.redirect_pc;
          end else begin
            pc_d = bus.redirect_pc;
          end
        end else if (!bus.stall) begin
          if_instr_d    = bus.instr_in;
          if_pc_d       = pc_q;
          if_pc4_d      = pc_plus4;
          if_valid_d    = 1'b1;
          pc_d          = pc_plus4;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      HALT: begin
        if_valid_d = 1'b0;
        halted_d   = 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.if_pc4      = if_pc4_q;
  assign bus.halted      = halted_q;
  assign bus.fault_pc    = fault_pc_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then
// randomized stall/redirect/reset traffic compared every cycle against a model.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  instr_fetch_if #(.PC_WIDTH(16)) bus ();

  instr_fetch #(
    .PC_WIDTH(16),
    .RESET_PC(16'h0000),
    .NOP     (NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    case (a)
      16'h0000: return 32'h00300413;
      16'h0004: return 32'h00100493;
      default:  return {a ^ 16'h5A3C, ~a};
    endcase
  endfunction

  assign bus.instr_in = rom_word(bus.pc);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a booting flag, a halted flag and the architectural registers.
  logic        m_boot, m_halt, m_valid;
  logic [15:0] m_pc, m_ifpc, m_ifpc4, m_fault;
  logic [31:0] m_instr, m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_boot <= 1'b1; m_halt <= 1'b0; m_valid <= 1'b0;
      m_pc <= 16'h0000; m_ifpc <= 16'h0; m_ifpc4 <= 16'h0; m_fault <= 16'h0;
      m_instr <= NOP; m_cnt <= 32'd0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (m_halt) begin
      m_valid <= 1'b0;
    end else if (bus.redirect) begin
      m_valid <= 1'b0;
      m_instr <= NOP;
      if (bus.redirect_pc % 4 != 0) begin
        m_halt  <= 1'b1;
        m_fault <= bus.redirect_pc;
      end else begin
        m_pc <= bus.redirect_pc;
      end
    end else if (!bus.stall) begin
      m_instr <= rom_word(m_pc);
      m_ifpc  <= m_pc;
      m_ifpc4 <= 16'((32'(m_pc) + 4) % 65536);
      m_pc    <= 16'((32'(m_pc) + 4) % 65536);
      m_valid <= 1'b1;
      m_cnt   <= m_cnt + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("pc",          32'(bus.pc),       32'(m_pc));
      chk("if_valid",    32'(bus.if_valid), 32'(m_valid));
      chk("if_instr",    bus.if_instr,      m_instr);
      chk("if_pc",       32'(bus.if_pc),    32'(m_ifpc));
      chk("if_pc4",      32'(bus.if_pc4),   32'(m_ifpc4));
      chk("halted",      32'(bus.halted),   32'(m_halt));
      chk("fault_pc",    32'(bus.fault_pc), 32'(m_fault));
      chk("fetch_count", bus.fetch_count,   m_cnt);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sync_reset();
    #1 rst = 1'b1;
    step(1);
    #1 rst = 1'b0;
  endtask

  initial begin
    int halt_cycles;
    int r;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0;
    step(2);
    chk("rst_pc",       32'(bus.pc),       32'h0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
    chk("rst_if_instr", bus.if_instr,      NOP);
    chk("rst_count",    bus.fetch_count,   32'h0);
    chk("rst_halted",   32'(bus.halted),   32'h0);

    #1 rst = 1'b0;
    step(1);
    chk("boot_if_valid", 32'(bus.if_valid), 32'h0);
    chk("boot_pc",       32'(bus.pc),       32'h0);
    step(1);
    chk("f0_instr", bus.if_instr,       32'h00300413);
    chk("f0_if_pc", 32'(bus.if_pc),     32'h0);
    chk("f0_pc4",   32'(bus.if_pc4),    32'h4);
    chk("f0_valid", 32'(bus.if_valid),  32'h1);
    step(1);
    chk("f1_instr", bus.if_instr,       32'h00100493);
    chk("f1_if_pc", 32'(bus.if_pc),     32'h4);
    chk("f1_pc",    32'(bus.pc),        32'h8);
    chk("f1_count", bus.fetch_count,    32'd2);
    chk("model_cnt_pin", m_cnt,         32'd2);

    step(1);
    chk("pre_stall_if_pc", 32'(bus.if_pc), 32'h8);
    bus.stall = 1'b1;
    step(3);
    chk("stall_if_pc", 32'(bus.if_pc),   32'h8);
    chk("stall_pc",    32'(bus.pc),      32'hC);
    chk("stall_count", bus.fetch_count,  32'd3);
    bus.stall = 1'b0;
    step(1);
    chk("unstall_if_pc", 32'(bus.if_pc), 32'hC);

    bus.redirect = 1'b1; bus.redirect_pc = 16'h0040;
    step(1);
    chk("goto40_pc", 32'(bus.pc), 32'h40);
    bus.redirect_pc = 16'h0034;
    step(1);
    chk("redir_valid", 32'(bus.if_valid), 32'h0);
    chk("redir_instr", bus.if_instr,      NOP);
    chk("redir_pc",    32'(bus.pc),       32'h34);
    bus.redirect = 1'b0;
    step(1);
    chk("redir_if_pc",   32'(bus.if_pc),    32'h34);
    chk("redir_f_valid", 32'(bus.if_valid), 32'h1);
    chk("model_ifpc_pin", 32'(m_ifpc),      32'h34);

    bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 16'h0010;
    step(1);
    chk("sr_pc",    32'(bus.pc),       32'h10);
    chk("sr_valid", 32'(bus.if_valid), 32'h0);
    bus.stall = 1'b0;

    bus.redirect_pc = 16'hFFFC;
    step(1);
    bus.redirect = 1'b0;
    step(1);
    chk("wrap_if_pc",  32'(bus.if_pc),  32'hFFFC);
    chk("wrap_if_pc4", 32'(bus.if_pc4), 32'h0);
    chk("wrap_pc",     32'(bus.pc),     32'h0);
    chk("wrap_halted", 32'(bus.halted), 32'h0);

    halt_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      bus.stall    = ($urandom_range(0, 3) == 0);
      bus.redirect = (r < 100);
      if (r < 15)
        bus.redirect_pc = {16'($urandom) & 16'hFFFC} | 16'($urandom_range(1, 3));
      else
        bus.redirect_pc = 16'($urandom) & 16'hFFFC;
      halt_cycles = m_halt ? halt_cycles + 1 : 0;
      if (halt_cycles > 6) begin
        halt_cycles = 0;
        sync_reset();
      end else if (r > 995) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
      step(1);
    end

    bus.stall = 1'b0; bus.redirect = 1'b0;
    sync_reset();
    step(2);
    bus.redirect = 1'b1; bus.redirect_pc = 16'h0022;
    step(1);
    bus.redirect = 1'b0;
    chk("mis_halted", 32'(bus.halted),   32'h1);
    chk("mis_fault",  32'(bus.fault_pc), 32'h22);
    chk("mis_valid",  32'(bus.if_valid), 32'h0);
    for (int k = 0; k < 10; k++) begin
      bus.stall = $urandom_range(0, 1) == 1;
      step(1);
      chk("halt_valid", 32'(bus.if_valid), 32'h0);
      chk("halt_flag",  32'(bus.halted),   32'h1);
    end
    #1 rst = 1'b1;
    #1;
    chk("rst_clears_halt", 32'(bus.halted), 32'h0);
    chk("rst_sets_pc",     32'(bus.pc),     32'h0);
    step(1);
    #1 rst = 1'b0;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the instruction memory ROM. Owns the program counter, drives the ROM address, captures the returned instruction into the IF/ID pipeline register, and handles stall, redirect (branch/jump) and misaligned-target faults. Downstream decode consumes `if_instr`, `if_pc` and `if_pc4` when `if_valid` is high.

## Interface
- `PC_WIDTH`, 16: width of the PC and ROM byte address.
- `RESET_PC`, 16'h0000: PC value loaded on reset; must be 4-byte aligned.
- `NOP`, 32'h00000013: bubble encoding (`addi x0,x0,0`) placed in `if_instr` on reset or flush.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `stall`  in  1  hold PC and IF/ID contents this cycle.
- `redirect`  in  1  taken branch or jump; load `redirect_pc`.
- `redirect_pc`  in  PC_WIDTH  redirect target byte address.
- `pc`  out  PC_WIDTH  current fetch address, driven to the ROM.
- `instr_in`  in  32  ROM output for `pc`, combinational from the ROM.
- `if_valid`  out  1  IF/ID holds a real instruction.
- `if_instr`  out  32  latched instruction.
- `if_pc`  out  PC_WIDTH  address of `if_instr`.
- `if_pc4`  out  PC_WIDTH  `if_pc + 4`, the link value for jal/jalr.
- `halted`  out  1  fetch stopped after a fault.
- `fault_pc`  out  PC_WIDTH  offending redirect target.
- `fetch_count`  out  32  number of instructions latched with `if_valid=1`.

## Operation
- States: BOOT, RUN and HALT.
- Reset (async) forces:
  - state = BOOT, `pc` = RESET_PC;
  - `if_valid` = 0, `if_instr` = NOP, `if_pc` = 0, `if_pc4` = 0;
  - `halted` = 0, `fault_pc` = 0, `fetch_count` = 0.
- BOOT: lasts exactly one cycle, giving the ROM time to settle.
  - `pc` holds and nothing is latched; `if_valid` stays 0.
  - Next state is RUN. `stall` and `redirect` are ignored in BOOT.
- RUN, priority order: redirect > stall > advance.
  - Redirect with aligned target (`redirect_pc[1:0]==0`): `pc` <= `redirect_pc`. IF/ID is flushed: `if_valid` <= 0, `if_instr` <= NOP. `if_pc` and `if_pc4` hold. `fetch_count` holds.
  - Redirect with misaligned target: next state HALT, `halted` <= 1, `fault_pc` <= `redirect_pc`, `if_valid` <= 0, `if_instr` <= NOP. `pc` holds.
  - Stall without redirect: `pc`, all `if_*` outputs and `fetch_count` hold.
  - Advance: `if_instr` <= `instr_in`, `if_pc` <= `pc`, `if_pc4` <= `pc`+4, `if_valid` <= 1, `pc` <= `pc`+4, `fetch_count` <= `fetch_count`+1.
- HALT: all registers hold, `if_valid` = 0 and `halted` = 1. Only `rst` exits HALT.
- Arithmetic:
  - `pc`+4 is computed modulo 2^PC_WIDTH, so 16'hFFFC wraps to 16'h0000 with no flag.
  - `fetch_count` wraps modulo 2^32.
- `pc` is a register output and never combinational from the inputs.

## Timing
- ROM read is combinational. An instruction at address A appears in `if_instr` on the first rising edge where `pc`==A and the stage advances. Fetch latency is 1 cycle from `pc` update.
- First valid fetch after reset deassertion:
  - edge 1 performs BOOT→RUN;
  - edge 2 latches ROM[RESET_PC] with `if_valid`=1.
- Redirect asserted at edge N:
  - `if_valid`=0 after edge N (one bubble);
  - `pc`=target after edge N;
  - target instruction is latched at edge N+1 if not stalled.
- Simultaneous `stall` and `redirect`: redirect wins and the flush still happens.
- Throughput is 1 instruction per cycle when `stall`=0 and `redirect`=0.
- Reset mid-operation takes effect immediately and asynchronously. No partially updated state survives.

## Test plan
- Reset then run, with ROM[0]=32'h00300413 and ROM[4]=32'h00100493. Release `rst` → one BOOT cycle with `if_valid`=0. Next edge: `if_instr`=32'h00300413, `if_pc`=0, `if_pc4`=4. Following edge: 32'h00100493 and `if_pc`=4, `pc`=8, `fetch_count`=2.
- Stall: assert `stall` for 3 cycles after `if_pc`=8. Response: `if_pc` stays 8, `pc` stays 12, `fetch_count` unchanged. Release → `if_pc`=12 next edge.
- Redirect: `redirect`=1, `redirect_pc`=16'h0034 while running at `pc`=16'h0040. Response: next edge `if_valid`=0 and `if_instr`=NOP. Following edge `if_pc`=16'h0034 and `if_valid`=1.
- Stall plus redirect in the same cycle, `redirect_pc`=16'h0010. Response: flush occurs and `pc`=16'h0010; stall is ignored.
- Misaligned redirect, `redirect_pc`=16'h0022. Response: `halted`=1, `fault_pc`=16'h0022, `if_valid` stays 0 for 10+ cycles. Asserting `rst` clears `halted` and sets `pc`=RESET_PC.
- Wrap-around: redirect to 16'hFFFC, then advance. Response: `if_pc`=16'hFFFC, `if_pc4`=16'h0000, next `pc`=16'h0000, no halt.
